// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one-outstanding req/ack fetch FSM, QDEPTH-entry prefetch queue,
// branch/jump/jr redirect. Perf counters are built only when FETCH_PERF_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [1:0]  redir_type,
    input  logic [31:0] redir_base,
    input  logic [31:0] seOut,
    input  logic [25:0] jidx,
    input  logic [31:0] reg_Da,
    output logic        addr_err,
    output logic [31:0] fetch_count,
    output logic [15:0] flush_count
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [31:0]    fetch_pc, fetch_pc_n;
    logic           req_n;
    logic [31:0]    addr_n;
    logic [PW-1:0]  rd_ptr, wr_ptr, rd_n, wr_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [31:0]    pc_q    [QDEPTH];
    logic [31:0]    instr_q [QDEPTH];
    logic           redirect, push, pop, err_n;
    logic [31:0]    target;
    logic [31:0]    head_pc_n, head_instr_n;

    // Next-state, queue bookkeeping and next registered outputs
    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        req_n        = imem_req;
        addr_n       = imem_addr;
        head_pc_n    = '0;
        head_instr_n = '0;
        redirect     = redir_valid && (redir_type != 2'b11);

        case (redir_type)
            2'b00:   target = redir_base + (seOut << 2);
            2'b01:   target = {redir_base[31:28], jidx, 2'b00};
            default: target = {reg_Da[31:2], 2'b00};
        endcase
        err_n = redirect && (redir_type == 2'b10) && (reg_Da[1:0] != 2'b00);

        push  = (state == REQ) && imem_ack && !redirect;
        pop   = instr_valid && !stall && !redirect;
        rd_n  = rd_ptr + PW'(pop);
        wr_n  = wr_ptr + PW'(push);
        cnt_n = cnt + CW'(push) - CW'(pop);
        if (redirect) begin
            rd_n       = '0;
            wr_n       = '0;
            cnt_n      = '0;
            fetch_pc_n = target;
        end

        case (state)
            IDLE: begin
                if (!redirect && (cnt_n < QFULL)) begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    addr_n  = fetch_pc;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end else begin
                        fetch_pc_n = imem_addr + 32'd4;
                        if (cnt_n < QFULL) begin
                            addr_n = imem_addr + 32'd4;
                        end else begin
                            state_n = IDLE;
                            req_n   = 1'b0;
                        end
                    end
                end else if (redirect) begin
                    // Request cannot be aborted; wait for its ack and discard the data
                    state_n = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase

        // Head after this edge: the entry being pushed if it lands at the new read slot
        if (cnt_n != '0) begin
            if (push && (wr_ptr == rd_n)) begin
                head_pc_n    = imem_addr;
                head_instr_n = imem_rdata;
            end else begin
                head_pc_n    = pc_q[rd_n];
                head_instr_n = instr_q[rd_n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            cnt         <= '0;
            instr_valid <= 1'b0;
            instr_pc    <= '0;
            instr_out   <= '0;
            addr_err    <= 1'b0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            imem_req    <= req_n;
            imem_addr   <= addr_n;
            rd_ptr      <= rd_n;
            wr_ptr      <= wr_n;
            cnt         <= cnt_n;
            instr_valid <= (cnt_n != '0);
            instr_pc    <= head_pc_n;
            instr_out   <= head_instr_n;
            addr_err    <= err_n;
        end
    end

    // Queue storage needs no reset; occupancy guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]    <= imem_addr;
            instr_q[wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (push) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic
// scored against a queue-based model of the instruction stream.
module tb_instr_fetch_unit;
    localparam int unsigned QD  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        redir_valid = 1'b0;
    logic [1:0]  redir_type = 2'b00;
    logic [31:0] redir_base = '0;
    logic [31:0] seOut = '0;
    logic [25:0] jidx = '0;
    logic [31:0] reg_Da = '0;
    logic        addr_err;
    logic [31:0] fetch_count;
    logic [15:0] flush_count;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid), .stall(stall),
        .redir_valid(redir_valid), .redir_type(redir_type), .redir_base(redir_base),
        .seOut(seOut), .jidx(jidx), .reg_Da(reg_Da), .addr_err(addr_err),
        .fetch_count(fetch_count), .flush_count(flush_count)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: expected delivered stream and next expected fetch address
    logic [31:0] mq_pc  [$];
    logic [31:0] mq_ins [$];
    logic [31:0] m_next;
    logic        m_taint;
    logic        m_err;
    logic [31:0] m_fcnt;
    logic [15:0] m_rcnt;
    int unsigned ack_pct   = 100;
    logic        force_ack = 1'b0;
    logic [31:0] key       = '0;

    function automatic void model_reset();
        mq_pc.delete();
        mq_ins.delete();
        m_next  = RPC;
        m_taint = 1'b0;
        m_err   = 1'b0;
        m_fcnt  = '0;
        m_rcnt  = '0;
    endfunction

    function automatic logic [31:0] model_target(input logic [1:0] t, input logic [31:0] base,
                                                 input logic [31:0] se, input logic [25:0] ji,
                                                 input logic [31:0] da);
        if (t == 2'b00) return base + se * 32'd4;
        if (t == 2'b01) return {base[31:28], ji, 2'b00};
        return da & 32'hFFFF_FFFC;
    endfunction

    function automatic void clear_redir();
        redir_valid = 1'b0;
        redir_type  = 2'b00;
        redir_base  = '0;
        seOut       = '0;
        jidx        = '0;
        reg_Da      = '0;
    endfunction

    // One clock: drive memory response, advance model, then score DUT against model
    task automatic cycle();
        logic        redir, accepted, pre_req, exp_v;
        logic [31:0] pre_addr, tgt, exp_pc, exp_ins, exp_fc;
        logic [15:0] exp_rc;
        if (force_ack) imem_ack = 1'b1;
        else imem_ack = imem_req && ($urandom_range(0, 99) < ack_pct);
        imem_rdata = imem_addr ^ key;
        pre_req  = imem_req;
        pre_addr = imem_addr;
        redir    = redir_valid && (redir_type != 2'b11);
        accepted = pre_req && imem_ack;
        tgt      = model_target(redir_type, redir_base, seOut, jidx, reg_Da);

        if (accepted && !m_taint && !redir) begin
            n_checks++;
            if (pre_addr !== m_next) begin
                n_fail++;
                $display("FAIL fetch_addr: got %h expected %h", pre_addr, m_next);
            end
        end
        if (!redir && mq_pc.size() != 0 && !stall) begin
            void'(mq_pc.pop_front());
            void'(mq_ins.pop_front());
        end
        if (accepted && !m_taint && !redir) begin
            mq_pc.push_back(m_next);
            mq_ins.push_back(m_next ^ key);
            m_next = m_next + 32'd4;
            m_fcnt = m_fcnt + 32'd1;
        end
        if (accepted) m_taint = 1'b0;
        if (redir) begin
            mq_pc.delete();
            mq_ins.delete();
            m_next = tgt;
            m_rcnt = m_rcnt + 16'd1;
            if (pre_req && !accepted) m_taint = 1'b1;
        end
        m_err = redir && (redir_type == 2'b10) && (reg_Da[1:0] != 2'b00);

        @(posedge clk);
        #1;
        exp_v   = (mq_pc.size() != 0);
        exp_pc  = exp_v ? mq_pc[0]  : 32'h0;
        exp_ins = exp_v ? mq_ins[0] : 32'h0;
`ifdef FETCH_PERF_EN
        exp_fc = m_fcnt;
        exp_rc = m_rcnt;
`else
        exp_fc = '0;
        exp_rc = '0;
`endif
        n_checks++;
        if (instr_valid !== exp_v) begin
            n_fail++;
            $display("FAIL instr_valid: got %b expected %b", instr_valid, exp_v);
        end
        n_checks++;
        if (instr_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL instr_pc: got %h expected %h", instr_pc, exp_pc);
        end
        n_checks++;
        if (instr_out !== exp_ins) begin
            n_fail++;
            $display("FAIL instr_out: got %h expected %h", instr_out, exp_ins);
        end
        n_checks++;
        if (addr_err !== m_err) begin
            n_fail++;
            $display("FAIL addr_err: got %b expected %b", addr_err, m_err);
        end
        n_checks++;
        if (fetch_count !== exp_fc || flush_count !== exp_rc) begin
            n_fail++;
            $display("FAIL perf_counts: got %0d/%0d expected %0d/%0d", fetch_count, flush_count, exp_fc, exp_rc);
        end
        if (pre_req && !accepted) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== pre_addr) begin
                n_fail++;
                $display("FAIL req_hold: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, pre_addr);
            end
        end
        if (redir && !(pre_req && !accepted)) begin
            n_checks++;
            if (imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL req_after_redir: got %b expected 0", imem_req);
            end
        end
        if (mq_pc.size() == QD) begin
            n_checks++;
            if (imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL full_no_req: got %b expected 0", imem_req);
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        clear_redir();
        stall     = 1'b0;
        imem_ack  = 1'b0;
        force_ack = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({imem_req, imem_addr, instr_out, instr_pc, instr_valid, addr_err, fetch_count, flush_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b addr=%h out=%h pc=%h v=%b", imem_req, imem_addr, instr_out, instr_pc, instr_valid);
        end
        ack_pct = 100;
        cycle();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RPC || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_req: got req=%b addr=%h v=%b expected 1 %h 0", imem_req, imem_addr, instr_valid, RPC);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        ack_pct = 100;
        key     = '0;
        cycle();
        for (int k = 0; k < 8; k++) begin
            cycle();
            n_checks++;
            if (instr_valid !== 1'b1 || instr_out !== RPC + 32'(4 * k) || instr_pc !== RPC + 32'(4 * k)) begin
                n_fail++;
                $display("FAIL stream_instr: got v=%b out=%h pc=%h expected %h", instr_valid, instr_out, instr_pc, RPC + 32'(4 * k));
            end
            n_checks++;
            if (imem_addr !== RPC + 32'(4 * (k + 1))) begin
                n_fail++;
                $display("FAIL stream_addr: got %h expected %h", imem_addr, RPC + 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        ack_pct = 100;
        key     = 32'h1111_0000;
        stall   = 1'b1;
        repeat (QD + 4) cycle();
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_out !== (RPC ^ key) || instr_pc !== RPC) begin
            n_fail++;
            $display("FAIL stall_frozen: got req=%b v=%b out=%h pc=%h", imem_req, instr_valid, instr_out, instr_pc);
        end
        stall = 1'b0;
        cycle();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RPC + 32'(4 * QD) || instr_pc !== RPC + 32'd4) begin
            n_fail++;
            $display("FAIL stall_resume: got req=%b addr=%h pc=%h expected 1 %h %h", imem_req, imem_addr, instr_pc, RPC + 32'(4 * QD), RPC + 32'd4);
        end
        repeat (12) cycle();
    endtask

    task automatic test_branch();
        apply_reset();
        ack_pct = 100;
        key     = 32'h0000_ABCD;
        repeat (4) cycle();
        redir_valid = 1'b1;
        redir_type  = 2'b00;
        redir_base  = 32'h0000_0100;
        seOut       = 32'hFFFF_FFFC;
        cycle();
        clear_redir();
        n_checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_flush: got v=%b req=%b expected 0 0", instr_valid, imem_req);
        end
        cycle();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_00F0) begin
            n_fail++;
            $display("FAIL branch_target: got req=%b addr=%h expected 1 000000f0", imem_req, imem_addr);
        end
        cycle();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_00F0) begin
            n_fail++;
            $display("FAIL branch_head: got v=%b pc=%h expected 1 000000f0", instr_valid, instr_pc);
        end
        repeat (4) cycle();
    endtask

    task automatic test_drop();
        apply_reset();
        ack_pct = 0;
        key     = 32'h5A5A_0000;
        cycle();
        redir_valid = 1'b1;
        redir_type  = 2'b00;
        redir_base  = 32'h0000_0200;
        seOut       = 32'h0000_0004;
        cycle();
        clear_redir();
        cycle();
        redir_valid = 1'b1;
        redir_type  = 2'b10;
        reg_Da      = 32'h0000_3000;
        cycle();
        clear_redir();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            n_fail++;
            $display("FAIL drop_hold: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, RPC);
        end
        ack_pct = 100;
        cycle();
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_discard: got req=%b v=%b expected 0 0", imem_req, instr_valid);
        end
        cycle();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
            n_fail++;
            $display("FAIL drop_last_target: got req=%b addr=%h expected 1 00003000", imem_req, imem_addr);
        end
        repeat (4) cycle();
    endtask

    task automatic test_jumps();
        apply_reset();
        ack_pct = 100;
        key     = 32'h0F0F_0000;
        repeat (3) cycle();
        redir_valid = 1'b1;
        redir_type  = 2'b10;
        reg_Da      = 32'h0000_2006;
        cycle();
        clear_redir();
        n_checks++;
        if (addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL jr_err_pulse: got %b expected 1", addr_err);
        end
        cycle();
        n_checks++;
        if (addr_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_2004) begin
            n_fail++;
            $display("FAIL jr_target: got err=%b req=%b addr=%h expected 0 1 00002004", addr_err, imem_req, imem_addr);
        end
        repeat (2) cycle();
        redir_valid = 1'b1;
        redir_type  = 2'b01;
        redir_base  = 32'h9000_0000;
        jidx        = 26'h10;
        cycle();
        clear_redir();
        cycle();
        n_checks++;
        if (imem_addr !== 32'h9000_0040) begin
            n_fail++;
            $display("FAIL jump_target: got %h expected 90000040", imem_addr);
        end
        repeat (3) cycle();
        redir_valid = 1'b1;
        redir_type  = 2'b11;
        reg_Da      = 32'h0000_0003;
        cycle();
        clear_redir();
        n_checks++;
        if (instr_valid !== 1'b1 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL type11_ignored: got v=%b err=%b expected 1 0", instr_valid, addr_err);
        end
        repeat (3) cycle();
    endtask

    task automatic test_midreset();
        apply_reset();
        ack_pct = 100;
        key     = 32'hC0DE_0000;
        repeat (5) cycle();
        ack_pct = 0;
        repeat (2) cycle();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({imem_req, imem_addr, instr_out, instr_pc, instr_valid, addr_err, fetch_count, flush_count} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got req=%b addr=%h v=%b fc=%0d rc=%0d", imem_req, imem_addr, instr_valid, fetch_count, flush_count);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        force_ack = 1'b1;
        cycle();
        force_ack = 1'b0;
        ack_pct   = 100;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RPC || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_restart: got req=%b addr=%h v=%b expected 1 %h 0", imem_req, imem_addr, instr_valid, RPC);
        end
        cycle();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== RPC) begin
            n_fail++;
            $display("FAIL midreset_first_instr: got v=%b pc=%h expected 1 %h", instr_valid, instr_pc, RPC);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        apply_reset();
        key = $urandom;
        for (int i = 0; i < 1500; i++) begin
            ack_pct     = (i < 700) ? 85 : 40;
            stall       = ($urandom_range(0, 3) == 0);
            redir_valid = ($urandom_range(0, 15) == 0);
            redir_type  = 2'($urandom_range(0, 3));
            r           = $urandom;
            redir_base  = {r[31:2], 2'b00};
            seOut       = 32'($urandom_range(0, 63)) - 32'd32;
            jidx        = 26'($urandom);
            reg_Da      = $urandom;
            cycle();
        end
        clear_redir();
        stall = 1'b0;
        repeat (10) cycle();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_drop();
        test_jumps();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
